// File: rtl/mic_capture_sched.sv
// mic_capture_sched: gated PDM clock, decimated sample strobe and frame sequencing for the mic array.
// Define MIC_WARMUP_EN to discard WARMUP samples after clock start; otherwise start goes straight to RUN.
`timescale 1ns/1ps
module mic_capture_sched #(
   parameter int PDM_HALF  = 8,
   parameter int DECIM     = 64,
   parameter int WARMUP    = 16,
   parameter int FRAME_LEN = 256
)(
   input  logic        clk_in,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] frame_count,
   input  logic        buf_ready,
   output logic        pdm_clk,
   output logic        pdm_rise,
   output logic        pdm_fall,
   output logic        sample_stb,
   output logic        frame_start,
   output logic        frame_done,
   output logic        busy,
   output logic        overrun,
   output logic [1:0]  state
);
   typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_DRAIN} state_t;
`ifdef MIC_WARMUP_EN
   localparam int WU = WARMUP;
`else
   localparam int WU = 0;
`endif
   localparam int HW = $clog2(PDM_HALF);
   localparam int DW = $clog2(DECIM);
   localparam int SW = $clog2(FRAME_LEN);
   localparam int WW = $clog2(WARMUP + 1);
   localparam logic [HW-1:0] H_LAST = HW'(PDM_HALF - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DECIM - 1);
   localparam logic [SW-1:0] S_LAST = SW'(FRAME_LEN - 1);
   localparam logic [WW-1:0] W_LAST = WW'(WU > 0 ? WU - 1 : 0);
   state_t st;
   logic [HW-1:0] hcnt;
   logic [DW-1:0] dcnt;
   logic [SW-1:0] sidx;
   logic [WW-1:0] wcnt;
   logic [15:0] fc, done_cnt;
   logic skip, tog, rise_ev, bnd, capturing, emit, in_frame, go_idle;
   always_comb begin
      tog       = hcnt == H_LAST;
      rise_ev   = tog && !pdm_clk;
      bnd       = rise_ev && dcnt == D_LAST;
      capturing = st == S_RUN || st == S_DRAIN;
      emit      = capturing && bnd && (sidx == '0 ? buf_ready : !skip);
      in_frame  = sidx != '0 && !skip;
      go_idle   = (st == S_WARMUP && stop) || (st == S_RUN && stop && !in_frame) ||
                  (frame_done && (st == S_DRAIN || (st == S_RUN && fc != '0 && done_cnt == fc)));
   end
   assign busy  = st != S_IDLE;
   assign state = st;
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         st          <= S_IDLE;
         pdm_clk     <= 1'b0;
         pdm_rise    <= 1'b0;
         pdm_fall    <= 1'b0;
         sample_stb  <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
         hcnt        <= '0;
         dcnt        <= '0;
         sidx        <= '0;
         wcnt        <= '0;
         fc          <= '0;
         done_cnt    <= '0;
         skip        <= 1'b0;
      end else if (st == S_IDLE || go_idle) begin
         pdm_clk     <= 1'b0;
         pdm_rise    <= 1'b0;
         pdm_fall    <= 1'b0;
         sample_stb  <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         hcnt        <= '0;
         dcnt        <= '0;
         sidx        <= '0;
         wcnt        <= '0;
         done_cnt    <= '0;
         skip        <= 1'b0;
         if (st == S_IDLE && start && !stop) begin
            st      <= WU == 0 ? S_RUN : S_WARMUP;
            fc      <= frame_count;
            overrun <= 1'b0;
         end else
            st <= S_IDLE;
      end else begin
         hcnt        <= tog ? '0 : hcnt + 1'b1;
         pdm_clk     <= tog ? !pdm_clk : pdm_clk;
         pdm_rise    <= rise_ev;
         pdm_fall    <= tog && pdm_clk;
         sample_stb  <= emit;
         frame_start <= emit && sidx == '0;
         frame_done  <= emit && sidx == S_LAST;
         if (rise_ev)
            dcnt <= dcnt == D_LAST ? '0 : dcnt + 1'b1;
         if (emit && sidx == S_LAST && done_cnt != 16'hFFFF)
            done_cnt <= done_cnt + 1'b1;
         // buf_ready is only consulted at the first boundary of a frame; a refusal skips the whole frame
         if (capturing && bnd) begin
            sidx <= sidx == S_LAST ? '0 : sidx + 1'b1;
            if (sidx == '0) begin
               skip <= !buf_ready;
               if (!buf_ready)
                  overrun <= 1'b1;
            end
         end
         if (st == S_WARMUP && bnd) begin
            wcnt <= wcnt == W_LAST ? '0 : wcnt + 1'b1;
            if (wcnt == W_LAST)
               st <= S_RUN;
         end
         if (st == S_RUN && stop)
            st <= S_DRAIN;
      end
   end
endmodule

// File: tb/tb_mic_capture_sched.sv
// tb_mic_capture_sched: directed checks of PDM clocking, warm-up, frames, skip/overrun, stop, drain and reset.
`timescale 1ns/1ps
module tb_mic_capture_sched;
`ifdef MIC_WARMUP_EN
   localparam int FS  = 46;
   localparam int WST = 1;
`else
   localparam int FS  = 14;
   localparam int WST = 2;
`endif
   logic clk_in = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, buf_ready = 1'b1;
   logic [15:0] frame_count = '0;
   logic pdm_clk, pdm_rise, pdm_fall, sample_stb, frame_start, frame_done, busy, overrun;
   logic [1:0] state;
   int checks = 0, errors = 0, k = 0, n_stb = 0, n_fd = 0, n_fs = 0;
   logic [31:0] exp_v;
   logic on, hi, rs, fl, sb;

   mic_capture_sched #(.PDM_HALF(2), .DECIM(4), .WARMUP(2), .FRAME_LEN(4)) dut (
      .clk_in(clk_in), .rst(rst), .start(start), .stop(stop), .frame_count(frame_count),
      .buf_ready(buf_ready), .pdm_clk(pdm_clk), .pdm_rise(pdm_rise), .pdm_fall(pdm_fall),
      .sample_stb(sample_stb), .frame_start(frame_start), .frame_done(frame_done),
      .busy(busy), .overrun(overrun), .state(state));

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] outs();
      return {21'b0, pdm_clk, pdm_rise, pdm_fall, sample_stb, frame_start, frame_done, busy, overrun, state};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      k++;
      n_stb += int'(sample_stb);
      n_fd  += int'(frame_done);
      n_fs  += int'(frame_start);
   endtask

   task automatic run_to(input int t);
      while (k < t) tick();
   endtask

   task automatic begin_cap(input logic [15:0] fc);
      frame_count = fc;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      n_stb = 0;
      n_fd = 0;
      n_fs = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk_in);
      #1;
      check("reset_outs", outs(), 0);
      rst = 1'b0;
      tick();
      check("idle_outs", outs(), 0);
      // single frame, every cycle checked against the timing formulas
      begin_cap(16'd1);
      for (int i = 0; i <= FS + 52; i++) begin
         on = k <= FS + 48;
         hi = on && k >= 2 && (k - 2) % 4 < 2;
         rs = on && k >= 2 && (k - 2) % 4 == 0;
         fl = on && k >= 4 && k % 4 == 0;
         sb = k >= FS && k <= FS + 48 && (k - FS) % 16 == 0;
         exp_v = {25'b0, hi, rs, fl, sb, k == FS, k == FS + 48, on};
         check($sformatf("s1_k%0d", k), outs() >> 3, exp_v);
         tick();
      end
      check("s1_nstb", n_stb, 4);
      // continuous capture stopped mid-frame drains the frame
      begin_cap(16'd0);
      run_to(FS + 24);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("drain_state", 32'(state), 3);
      run_to(FS + 30);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("drain_stop_ignored", 32'(state), 3);
      run_to(FS + 48);
      check("drain_fd", 32'(frame_done), 1);
      tick();
      check("drain_idle", 32'({state, busy, pdm_clk}), 0);
      check("drain_nstb", n_stb, 4);
      // first frame refused by the buffer, then two frames complete
      buf_ready = 1'b0;
      tick();
      begin_cap(16'd2);
      run_to(FS + 4);
      buf_ready = 1'b1;
      check("skip_overrun", 32'(overrun), 1);
      check("skip_nstb", n_stb, 0);
      run_to(FS + 112);
      check("skip_fd1", 32'(frame_done), 1);
      check("skip_run", 32'(state), 2);
      run_to(FS + 176);
      check("skip_fd2", 32'(frame_done), 1);
      tick();
      check("skip_idle", 32'({busy, state}), 0);
      check("skip_nstb2", n_stb, 8);
      check("skip_nfs", n_fs, 2);
      // early stop, overrun cleared by start, start+stop in idle
      begin_cap(16'd1);
      check("ovr_cleared", 32'(overrun), 0);
      run_to(10);
      check("early_state", 32'(state), WST);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("early_idle", 32'({busy, state, pdm_clk}), 0);
      check("early_nstb", n_stb, 0);
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      check("startstop_busy", 32'(busy), 0);
      tick();
      check("startstop_state", 32'(state), 0);
      // asynchronous reset mid-capture, then a fresh capture
      begin_cap(16'd1);
      run_to(50);
      check("rst_nfd", n_fd, 0);
      rst = 1'b1;
      #1;
      check("rst_async", outs(), 0);
      @(posedge clk_in);
      #1;
      rst = 1'b0;
      tick();
      begin_cap(16'd1);
      run_to(FS - 1);
      check("fresh_pre", 32'(sample_stb), 0);
      tick();
      check("fresh_first", 32'({sample_stb, frame_start}), 3);
      run_to(FS + 48);
      check("fresh_fd", 32'(frame_done), 1);
      tick();
      check("fresh_idle", 32'({busy, pdm_clk}), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mic_capture_sched.md
# mic_capture_sched

Capture scheduler for the PDM microphone array. From the fabric clock it generates the gated PDM microphone clock and its edge strobes, a decimated sample strobe, and frame boundaries. Each capture is sequenced through mic warm-up, a fixed number of frames, and a clean stop. It replaces free-running divider taps with a start/stop-controlled, frame-aware sequencer. It sits between the PS control registers and the per-mic CIC/beamforming datapath.

## Interface
- PDM_HALF, 8: clk_in cycles per PDM clock half-period; ≥2.
- DECIM, 64: PDM clock periods per output sample; ≥2.
- WARMUP, 16: samples discarded after clock start; ≥1.
- FRAME_LEN, 256: samples per frame; ≥2.
- clk_in  in  1  fabric clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle capture request.
- stop  in  1  one-cycle stop request.
- frame_count  in  16  frames to capture; 0 = continuous until stop; sampled on accepted start.
- buf_ready  in  1  downstream buffer can accept a full frame.
- pdm_clk  out  1  registered microphone clock.
- pdm_rise  out  1  one-cycle pulse in the first cycle pdm_clk is high.
- pdm_fall  out  1  one-cycle pulse in the first cycle pdm_clk is low.
- sample_stb  out  1  one-cycle decimated sample strobe.
- frame_start  out  1  pulse with the first sample_stb of a frame.
- frame_done  out  1  pulse with the last sample_stb of a frame.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky; a frame was skipped.
- state  out  2  IDLE=0, WARMUP=1, RUN=2, DRAIN=3.

## Operation
- Reset values: all outputs 0; state IDLE; all counters 0.
- IDLE: pdm_clk held low, no strobes. start accepted → WARMUP, latches frame_count, clears overrun.
- start while busy is ignored. start and stop in the same IDLE cycle: stop wins, so the block stays IDLE.
- Clock generation, active in WARMUP, RUN and DRAIN:
  - Half counter runs 0..PDM_HALF-1 and toggles pdm_clk at terminal count.
  - Decimation counter counts pdm_rise events 0..DECIM-1. Every DECIM-th rise is a sample boundary.
- WARMUP: counts WARMUP boundaries without emitting sample_stb, then → RUN.
  - stop in WARMUP → IDLE next cycle.
- RUN: each boundary emits sample_stb coincident with pdm_rise. The sample index runs 0..FRAME_LEN-1.
  - At index 0, buf_ready is sampled. If it is low, the whole frame is skipped: no sample_stb, frame_start or frame_done, and overrun is set. Skipped frames do not count.
  - After a completed frame, if the completed-frame count equals frame_count (nonzero) → IDLE.
- stop in RUN: → DRAIN if a frame is in progress, otherwise (between frames or during a skipped frame) → IDLE.
  - DRAIN finishes the current frame, then → IDLE. stop in DRAIN is ignored.
- IDLE entry: pdm_clk forced low and all counters cleared on the same edge.
- rst asserted mid-operation: immediate return to reset values. No frame_done is issued.
- Completed-frame counter is 16 bits and saturates; in continuous mode it never terminates capture.

## Timing
- Let t0 be the first cycle with busy=1, which is the cycle after start is sampled.
- First pdm_rise at t0+PDM_HALF-1+1. PDM period is 2·PDM_HALF cycles; pdm_fall is PDM_HALF cycles after each pdm_rise.
- The first sample_stb lands on rise number (WARMUP+1)·DECIM.
- frame_done and IDLE: frame_done pulses in cycle t; busy=0 and state=IDLE in t+1.
- stop/start latency: one cycle from a sampled stop to its state change (IDLE or DRAIN); one cycle from an accepted start to WARMUP.

## Configuration
- MIC_WARMUP_EN defined: WARMUP state and WARMUP parameter are active as described.
- MIC_WARMUP_EN undefined: start goes directly to RUN. The first sample_stb is on rise number DECIM, and state never reads 1.

## Test plan
Parameters: PDM_HALF=2, DECIM=4, WARMUP=2, FRAME_LEN=4.
- Start with frame_count=1, buf_ready=1 → pdm_rise at t0+2 and every 4 cycles; sample_stb at t0+46/62/78/94; frame_start at t0+46; frame_done at t0+94; busy=0 at t0+95.
- Same stimulus with MIC_WARMUP_EN undefined → first sample_stb at t0+14; frame_done at t0+62.
- frame_count=0, stop asserted at t0+70 → DRAIN until frame_done at t0+94; IDLE at t0+95; pdm_clk=0.
- frame_count=2, buf_ready=0 at t0+46 then 1 → frame 1 skipped, overrun=1; frames complete at t0+158 and t0+222; IDLE at t0+223.
- stop at t0+10 (WARMUP) → IDLE at t0+11, no sample_stb. start+stop together in IDLE → stays IDLE.
- rst asserted at t0+50 → all outputs 0 asynchronously; a fresh start afterwards behaves as in the first scenario.
